// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the fence.i flush unit and its OBI helpers.
package cv32e40x_pkg;

  localparam int unsigned FENCEI_TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INVAL = 2'd2,
    ACK   = 2'd3
  } fencei_state_e;

endpackage

// File: rtl/cv32e40x_obi_outstanding_cnt.sv
// Saturating count of granted-but-unanswered OBI transactions; usable on the
// instruction or data side.
module cv32e40x_obi_outstanding_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_i,
  input  logic                                 gnt_i,
  input  logic                                 rvalid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] cnt_o,
  output logic                                 empty_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             inc;
  logic             dec;

  assign inc = req_i & gnt_i;
  assign dec = rvalid_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_W'(MAX_OUTSTANDING))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cv32e40x_fencei_flush_unit.sv
// fence.i flush sequencer: drain outstanding fetches, invalidate, acknowledge.
// Optional watchdog enabled by defining CV32E40X_FENCEI_TIMEOUT_EN.
module cv32e40x_fencei_flush_unit
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = FENCEI_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fencei_flush_req_i,
  output logic fencei_flush_ack_o,
  input  logic instr_req_i,
  input  logic instr_gnt_i,
  input  logic instr_rvalid_i,
  output logic inval_req_o,
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
  output logic timeout_o,
`endif
  input  logic inval_ack_i,
  output logic busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  fencei_state_e    state_q;
  fencei_state_e    state_d;
  logic [CNT_W-1:0] outstanding;
  logic             cnt_empty;
  logic             drained;
  logic             timeout_hit;

  cv32e40x_obi_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (instr_req_i),
    .gnt_i    (instr_gnt_i),
    .rvalid_i (instr_rvalid_i),
    .cnt_o    (outstanding),
    .empty_o  (cnt_empty)
  );

  // A new request in the same cycle would be fetched with stale code.
  assign drained = cnt_empty & ~instr_req_i;

`ifdef CV32E40X_FENCEI_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q;
  logic            timeout_q;
  logic            waiting;

  assign waiting     = (state_q == DRAIN) || (state_q == INVAL);
  assign timeout_hit = waiting && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q <= waiting ? (wdog_q + WD_W'(1)) : '0;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign unused_cfg  = ^{TIMEOUT_CYCLES, outstanding};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fencei_flush_req_i) state_d = DRAIN;
      DRAIN:   if (drained)            state_d = INVAL;
      INVAL:   if (inval_ack_i)        state_d = ACK;
      ACK:                             state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
    // The watchdog overrides any normal transition and drops inval_req_o with it.
    if (timeout_hit) begin
      state_d = ACK;
    end
  end

  // Outputs decode the state register only, so they are glitch-free.
  always_comb begin
    fencei_flush_ack_o = (state_q == ACK);
    inval_req_o        = (state_q == INVAL);
    busy_o             = (state_q != IDLE);
  end

endmodule

// File: tb/tb_cv32e40x_fencei_flush_unit.sv
// Self-checking bench: directed vector table, hand sequences, random vs. model.
module tb_cv32e40x_fencei_flush_unit;

  localparam int MAX_OUT = 2;
  localparam int TMO     = 16;

  typedef struct {
    logic req;
    logic ireq;
    logic gnt;
    logic rvalid;
    logic iack;
    logic e_ack;
    logic e_inval;
    logic e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fencei_flush_req = 1'b0;
  logic fencei_flush_ack;
  logic instr_req = 1'b0;
  logic instr_gnt = 1'b0;
  logic instr_rvalid = 1'b0;
  logic inval_req;
  logic inval_ack = 1'b0;
  logic busy;
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
  logic timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: flush progress flags, outstanding count, watchdog cycles.
  bit m_draining, m_invalidating, m_acking, m_timeout;
  int m_cnt, m_wait_cycles;

  vec_t vecs[$];

  always #5 clk = ~clk;

  cv32e40x_fencei_flush_unit #(
    .MAX_OUTSTANDING(MAX_OUT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fencei_flush_req_i (fencei_flush_req),
    .fencei_flush_ack_o (fencei_flush_ack),
    .instr_req_i        (instr_req),
    .instr_gnt_i        (instr_gnt),
    .instr_rvalid_i     (instr_rvalid),
    .inval_req_o        (inval_req),
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
    .timeout_o          (timeout),
`endif
    .inval_ack_i        (inval_ack),
    .busy_o             (busy)
  );

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mk(input logic req, ireq, gnt, rvalid, iack,
                              input logic e_ack, e_inval, e_busy);
    vec_t v;
    v.req = req; v.ireq = ireq; v.gnt = gnt; v.rvalid = rvalid; v.iack = iack;
    v.e_ack = e_ack; v.e_inval = e_inval; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic model_reset();
    m_draining = 0; m_invalidating = 0; m_acking = 0;
    m_timeout = 0; m_cnt = 0; m_wait_cycles = 0;
  endtask

  task automatic model_step(input logic req, ireq, gnt, rvalid, iack);
    int  cnt_next;
    bit  nd, ni, na;
    bool_granted: begin end
    cnt_next = m_cnt;
    if ((ireq && gnt) && !rvalid && m_cnt < MAX_OUT) cnt_next = m_cnt + 1;
    else if (rvalid && !(ireq && gnt) && m_cnt > 0) cnt_next = m_cnt - 1;
    nd = 0; ni = 0; na = 0;
    if (m_acking) begin
      // flush finished; back to idle regardless of the request
    end else if (m_invalidating) begin
      if (iack) na = 1; else ni = 1;
    end else if (m_draining) begin
      if (m_cnt == 0 && !ireq) ni = 1; else nd = 1;
    end else if (req) begin
      nd = 1;
    end
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
    if (m_draining || m_invalidating) begin
      m_wait_cycles++;
      if (m_wait_cycles == TMO) begin
        nd = 0; ni = 0; na = 1; m_timeout = 1;
      end
    end else begin
      m_wait_cycles = 0;
    end
`endif
    m_draining = nd; m_invalidating = ni; m_acking = na;
    m_cnt = cnt_next;
  endtask

  task automatic cycle(input logic req, ireq, gnt, rvalid, iack);
    fencei_flush_req = req; instr_req = ireq; instr_gnt = gnt;
    instr_rvalid = rvalid; inval_ack = iack;
    @(posedge clk);
    model_step(req, ireq, gnt, rvalid, iack);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ack"},   fencei_flush_ack, m_acking);
    check({tag, ".inval"}, inval_req,        m_invalidating);
    check({tag, ".busy"},  busy,             m_draining | m_invalidating | m_acking);
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
    check({tag, ".timeout"}, timeout, m_timeout);
`endif
  endtask

  task automatic do_reset();
    fencei_flush_req = 0; instr_req = 0; instr_gnt = 0; instr_rvalid = 0; inval_ack = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    // Directed table, starting from reset with nothing outstanding.
    vecs.push_back(mk(1,0,0,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 1,0,1));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,1,1,1,0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,1,0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,1));
    vecs.push_back(mk(1,0,0,0,1, 0,1,1));
    vecs.push_back(mk(1,0,0,0,1, 1,0,1));
    vecs.push_back(mk(1,0,0,0,1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 1,0,1));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0));

    do_reset();
    check("reset.ack",   fencei_flush_ack, 1'b0);
    check("reset.inval", inval_req,        1'b0);
    check("reset.busy",  busy,             1'b0);
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
    check("reset.timeout", timeout, 1'b0);
`endif

    foreach (vecs[i]) begin
      cycle(vecs[i].req, vecs[i].ireq, vecs[i].gnt, vecs[i].rvalid, vecs[i].iack);
      check($sformatf("vec%0d.ack", i),   fencei_flush_ack, vecs[i].e_ack);
      check($sformatf("vec%0d.inval", i), inval_req,        vecs[i].e_inval);
      check($sformatf("vec%0d.busy", i),  busy,             vecs[i].e_busy);
    end

    // Two fetches in flight, then a flush that waits for both responses.
    do_reset();
    cycle(0,1,1,0,0);
    cycle(0,1,1,0,0);
    cycle(1,0,0,0,0);
    cycle(0,0,0,0,0);
    cycle(0,0,0,1,0);
    check("drain2.inval_after_first_rvalid", inval_req, 1'b0);
    cycle(0,0,0,0,0);
    cycle(0,0,0,1,0);
    check("drain2.inval_at_last_rvalid", inval_req, 1'b0);
    check("drain2.busy", busy, 1'b1);
    cycle(0,0,0,0,0);
    check("drain2.inval_rise", inval_req, 1'b1);
    cycle(0,0,0,0,0);
    check("drain2.inval_held", inval_req, 1'b1);
    check("drain2.no_early_ack", fencei_flush_ack, 1'b0);
    cycle(0,0,0,0,1);
    check("drain2.ack_after_iack", fencei_flush_ack, 1'b1);
    check("drain2.inval_drop", inval_req, 1'b0);

    // Reset asserted mid-invalidate aborts the flush without a later ack.
    do_reset();
    cycle(1,0,0,0,0);
    cycle(0,0,0,0,0);
    check("rst_mid.inval_before", inval_req, 1'b1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_mid.inval_async", inval_req, 1'b0);
    check("rst_mid.busy_async",  busy,      1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      cycle(0,0,0,0,1);
      check($sformatf("rst_mid.no_ack%0d", k), fencei_flush_ack, 1'b0);
    end

`ifdef CV32E40X_FENCEI_TIMEOUT_EN
    // Invalidate never acknowledged: watchdog forces the ack.
    begin
      int n_wait;
      bit seen;
      do_reset();
      cycle(1,0,0,0,0);
      seen = 0;
      n_wait = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
        cycle(0,0,0,0,0);
        if (fencei_flush_ack === 1'b1) begin
          seen = 1;
          n_wait = k;
        end
      end
      check("tmo.ack_seen", seen, 1'b1);
      check("tmo.ack_cycle_is_16", n_wait == TMO, 1'b1);
      check("tmo.inval_dropped", inval_req, 1'b0);
      check("tmo.flag_set", timeout, 1'b1);
      repeat (3) cycle(0,0,0,0,1);
      check("tmo.flag_sticky", timeout, 1'b1);
      do_reset();
      check("tmo.flag_cleared", timeout, 1'b0);
    end
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic r_req, r_ireq, r_gnt, r_rv, r_iack;
      r_req  = ($urandom_range(0, 3) == 0);
      r_ireq = ($urandom_range(0, 2) == 0);
      r_gnt  = $urandom_range(0, 1) != 0;
      r_rv   = ($urandom_range(0, 2) == 0);
      r_iack = $urandom_range(0, 1) != 0;
      cycle(r_req, r_ireq, r_gnt, r_rv, r_iack);
      check_model($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
